// File: rtl/axi4_slave_write_responder.sv
// AXI4 write-only slave backed by a byte-addressed memory, one transaction at a time.
// Burst checks happen at AW acceptance; the B channel reports the worst error seen.
module axi4_slave_write_responder #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MEM_BYTES = 4096,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [3:0]                 awid,
    input  logic [ADDRESS_WIDTH-1:0]   awaddr,
    input  logic [7:0]                 awlen,
    input  logic [2:0]                 awsize,
    input  logic [1:0]                 awburst,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [DATA_WIDTH/8-1:0]    wstrb,
    input  logic                       wlast,
    input  logic                       wvalid,
    output logic                       wready,
    output logic [3:0]                 bid,
    output logic [1:0]                 bresp,
    output logic                       bvalid,
    input  logic                       bready,
    input  logic [ADDRESS_WIDTH-1:0]   dbg_addr,
    output logic [7:0]                 dbg_data
);

    localparam int unsigned STRB = DATA_WIDTH / 8;
    localparam int unsigned STRB_LOG = $clog2(STRB);
    localparam int unsigned MEM_AW = $clog2(MEM_BYTES);
    localparam int unsigned XW = ADDRESS_WIDTH + 1;
    localparam logic [XW-1:0] LIMIT = {1'b0, BASE_ADDR} + XW'(MEM_BYTES);

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;
    localparam logic [1:0] BurstRsvd  = 2'b11;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;
    localparam logic [1:0] RespDecerr = 2'b11;

    typedef enum logic [1:0] {StIdle, StData, StResp} state_e;

    state_e state_q, state_d;

    logic                     ready_q;
    logic [3:0]               id_q;
    logic [1:0]               err_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [7:0]               len_q;
    logic [7:0]               cnt_q;
    logic [2:0]               size_q;
    logic [1:0]               burst_q;
    logic [ADDRESS_WIDTH-1:0] wrap_lower_q;
    logic [ADDRESS_WIDTH-1:0] wrap_end_q;

    logic [7:0] mem [MEM_BYTES];

    function automatic logic in_range(input logic [ADDRESS_WIDTH-1:0] a);
        return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < LIMIT);
    endfunction

    logic aw_hs, w_hs, w_end, last_beat, beat_oob, mem_we;
    logic [1:0] aw_err, beat_err;
    logic [ADDRESS_WIDTH-1:0] aw_total, aw_lower;
    logic [ADDRESS_WIDTH-1:0] beat_bytes, beat_incr, beat_next, beat_base;
    logic [ADDRESS_WIDTH-1:0] lane_addr [STRB];
    logic [MEM_AW-1:0]        lane_idx [STRB];
    logic [STRB-1:0]          lane_ok;
    logic [MEM_AW-1:0]        dbg_idx;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    // Burst legality is fixed at AW time; the wrap window is a power of two for legal lengths.
    always_comb begin
        aw_total = (ADDRESS_WIDTH'(awlen) + ADDRESS_WIDTH'(1)) << awsize;
        aw_lower = awaddr & ~(aw_total - ADDRESS_WIDTH'(1));
        aw_err = RespOkay;
        if (!in_range(awaddr)) begin
            aw_err = RespDecerr;
        end else if (awburst == BurstRsvd || 32'(awsize) > STRB_LOG ||
                     (awburst == BurstWrap && !(awlen == 8'd1 || awlen == 8'd3 ||
                                                awlen == 8'd7 || awlen == 8'd15))) begin
            aw_err = RespSlverr;
        end
    end

    always_comb begin
        beat_bytes = ADDRESS_WIDTH'(1) << size_q;
        beat_incr  = (addr_q & ~(beat_bytes - ADDRESS_WIDTH'(1))) + beat_bytes;
        case (burst_q)
            BurstFixed: beat_next = addr_q;
            BurstIncr:  beat_next = beat_incr;
            BurstWrap:  beat_next = (beat_incr == wrap_end_q) ? wrap_lower_q : beat_incr;
            default:    beat_next = addr_q;
        endcase
    end

    always_comb begin
        last_beat = (cnt_q == len_q);
        w_end     = w_hs && (wlast || last_beat);
        beat_oob  = (burst_q == BurstIncr) && !in_range(addr_q);
        mem_we    = w_hs && (err_q == RespOkay) && !beat_oob;
        beat_err  = err_q;
        if (beat_oob) begin
            beat_err = RespDecerr;
        end else if ((wlast != last_beat) && err_q == RespOkay) begin
            beat_err = RespSlverr;
        end
    end

    always_comb begin
        beat_base = (addr_q & ~ADDRESS_WIDTH'(STRB - 1)) - BASE_ADDR;
        for (int unsigned i = 0; i < STRB; i++) begin
            lane_addr[i] = beat_base + ADDRESS_WIDTH'(i);
            lane_ok[i]   = lane_addr[i] < ADDRESS_WIDTH'(MEM_BYTES);
            lane_idx[i]  = MEM_AW'(lane_addr[i]);
        end
        dbg_idx = MEM_AW'(dbg_addr - BASE_ADDR);
    end

    // FSM state register
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= StIdle;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (aw_hs) state_d = StData;
            StData: if (w_end) state_d = StResp;
            StResp: if (bready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        awready = (state_q == StIdle) && ready_q;
        wready  = (state_q == StData);
        bvalid  = (state_q == StResp);
        bid     = id_q;
        bresp   = err_q;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            id_q         <= '0;
            err_q        <= RespOkay;
            addr_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            size_q       <= '0;
            burst_q      <= BurstFixed;
            wrap_lower_q <= '0;
            wrap_end_q   <= '0;
        end else if (aw_hs) begin
            id_q         <= awid;
            err_q        <= aw_err;
            addr_q       <= awaddr;
            len_q        <= awlen;
            cnt_q        <= '0;
            size_q       <= awsize;
            burst_q      <= awburst;
            wrap_lower_q <= aw_lower;
            wrap_end_q   <= aw_lower + aw_total;
        end else if (w_hs) begin
            err_q  <= beat_err;
            addr_q <= beat_next;
            cnt_q  <= cnt_q + 8'd1;
        end
    end

    // Memory survives reset; only the debug output register is cleared.
    always_ff @(posedge aclk) begin
        for (int unsigned i = 0; i < STRB; i++) begin
            if (mem_we && wstrb[i] && lane_ok[i]) begin
                mem[lane_idx[i]] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            dbg_data <= '0;
        end else if (in_range(dbg_addr)) begin
            dbg_data <= mem[dbg_idx];
        end else begin
            dbg_data <= '0;
        end
    end

endmodule

// File: tb/tb_axi4_slave_write_responder.sv
// Bench for axi4_slave_write_responder: table of bursts with scoreboarded B responses
// and debug-port memory checks, plus hand-written handshake and reset sequences.
module tb_axi4_slave_write_responder;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] dbg_addr = '0;
    logic [7:0]  dbg_data;

    always #5 aclk = ~aclk;

    axi4_slave_write_responder dut (
        .aclk(aclk), .areset(areset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Check slots: ca holds four 16-bit addresses, cd four bytes, slot 0 in the low bits.
    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [7:0]  strb0;
        logic [7:0]  strb1;
        logic [31:0] data;
        int          last_beat;
        logic [1:0]  resp;
        int          nchk;
        logic [63:0] ca;
        logic [31:0] cd;
    } vec_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic add_vec(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [7:0] strb0, input logic [7:0] strb1,
                           input logic [31:0] data, input int last_beat, input logic [1:0] resp,
                           input int nchk, input logic [63:0] ca, input logic [31:0] cd);
        vec_t v;
        v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
        v.strb0 = strb0; v.strb1 = strb1; v.data = data; v.last_beat = last_beat;
        v.resp = resp; v.nchk = nchk; v.ca = ca; v.cd = cd;
        vecs.push_back(v);
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [1:0] resp);
        exp_t e;
        e.id = id;
        e.resp = resp;
        sb.push_back(e);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
        awvalid = 1'b1;
        for (int n = 0; n < 20 && !awready; n++) tick();
        check("aw_ready", awready, 1);
        tick();
        awvalid = 1'b0;
        check("w_ready_after_aw", wready, 1);
    endtask

    task automatic do_beat(input logic [7:0] b, input logic [7:0] strb, input logic last);
        wdata = {8{b}};
        wstrb = strb;
        wlast = last;
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        wlast = 1'b0;
    endtask

    task automatic do_b(input int hold);
        exp_t e;
        for (int n = 0; n < 20 && !bvalid; n++) tick();
        check("b_valid", bvalid, 1);
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: got a B response, expected none outstanding");
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i < hold; i++) begin
            check("b_hold_valid", bvalid, 1);
            check("b_hold_bid", bid, e.id);
            check("b_hold_bresp", bresp, e.resp);
            check("b_hold_awready", awready, 0);
            tick();
        end
        check("bid", bid, e.id);
        check("bresp", bresp, e.resp);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("b_done_valid", bvalid, 0);
        check("aw_ready_after_b", awready, 1);
    endtask

    task automatic dbg_read(input logic [31:0] a, input logic [7:0] exp);
        dbg_addr = a;
        tick();
        check($sformatf("mem[0x%0h]", a), dbg_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int nb;
        vec_t v;

        areset = 1'b1;
        repeat (3) tick();
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_bid", bid, 0);
        check("rst_bresp", bresp, 0);
        check("rst_dbg_data", dbg_data, 0);
        areset = 1'b0;
        tick();
        check("awready_first_edge", awready, 1);

        //      id    addr       len  sz burst  s0     s1     data          last resp  n  ca / cd
        add_vec(4'h3, 32'h100,   3,   3, 2'b01, 8'hFF, 8'hFF, 32'h44332211, 3,   2'b00, 4,
                {16'h11F, 16'h108, 16'h107, 16'h100}, {8'h44, 8'h22, 8'h11, 8'h11});
        add_vec(4'h5, 32'h118,   3,   3, 2'b10, 8'hFF, 8'hFF, 32'hA4A3A2A1, 3,   2'b00, 4,
                {16'h117, 16'h108, 16'h100, 16'h118}, {8'hA4, 8'hA3, 8'hA2, 8'hA1});
        add_vec(4'h7, 32'h203,   1,   0, 2'b00, 8'h08, 8'h08, 32'h000055AA, 1,   2'b00, 1,
                {48'h0, 16'h203}, {24'h0, 8'h55});
        add_vec(4'h9, 32'h2000,  1,   3, 2'b01, 8'hFF, 8'hFF, 32'h0000EFEE, 1,   2'b11, 2,
                {32'h0, 16'h100, 16'h118}, {16'h0, 8'hA2, 8'hA1});
        add_vec(4'h2, 32'h300,   3,   3, 2'b01, 8'hFF, 8'hFF, 32'h64636261, 1,   2'b10, 2,
                {32'h0, 16'h308, 16'h300}, {16'h0, 8'h62, 8'h61});
        add_vec(4'h4, 32'h100,   0,   3, 2'b11, 8'hFF, 8'hFF, 32'h00000099, 0,   2'b10, 1,
                {48'h0, 16'h100}, {24'h0, 8'hA2});
        add_vec(4'h8, 32'h108,   0,   4, 2'b01, 8'hFF, 8'hFF, 32'h00000098, 0,   2'b10, 1,
                {48'h0, 16'h108}, {24'h0, 8'hA3});
        add_vec(4'hB, 32'h110,   2,   3, 2'b10, 8'hFF, 8'hFF, 32'h00979695, 2,   2'b10, 1,
                {48'h0, 16'h110}, {24'h0, 8'hA4});
        add_vec(4'hC, 32'h400,   1,   3, 2'b01, 8'hFF, 8'hFF, 32'h00007271, 255, 2'b10, 2,
                {32'h0, 16'h408, 16'h400}, {16'h0, 8'h72, 8'h71});
        add_vec(4'hD, 32'hFF8,   1,   3, 2'b01, 8'hFF, 8'hFF, 32'h00008281, 1,   2'b11, 2,
                {32'h0, 16'hFFF, 16'hFF8}, {16'h0, 8'h81, 8'h81});
        add_vec(4'hE, 32'h500,   1,   2, 2'b01, 8'h0F, 8'hF0, 32'h00009291, 1,   2'b00, 4,
                {16'h507, 16'h504, 16'h503, 16'h500}, {8'h92, 8'h92, 8'h91, 8'h91});
        add_vec(4'hF, 32'h608,   1,   3, 2'b10, 8'hFF, 8'hFF, 32'h0000B2B1, 1,   2'b00, 2,
                {32'h0, 16'h600, 16'h608}, {16'h0, 8'hB2, 8'hB1});

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            do_aw(v.id, v.addr, v.len, v.size, v.burst, v.resp);
            nb = (v.last_beat <= int'(v.len)) ? v.last_beat + 1 : int'(v.len) + 1;
            for (int k = 0; k < nb; k++) begin
                do_beat(v.data[8*(k%4) +: 8], (k % 2 == 1) ? v.strb1 : v.strb0, k == v.last_beat);
            end
            check($sformatf("b_latency_vec%0d", i), bvalid, 1);
            do_b(0);
            for (int c = 0; c < v.nchk; c++) begin
                dbg_read({16'h0, v.ca[16*c +: 16]}, v.cd[8*c +: 8]);
            end
        end

        // A debug read of a byte written in the same cycle returns the old contents.
        do_aw(4'h1, 32'h100, 0, 3, 2'b01, 2'b00);
        dbg_addr = 32'h100;
        do_beat(8'hD0, 8'hFF, 1'b1);
        check("dbg_old_value", dbg_data, 8'hA2);
        check("b_latency_rdw", bvalid, 1);
        do_b(0);
        dbg_read(32'h100, 8'hD0);
        dbg_read(32'h3000, 8'h00);

        // B channel held off by bready for five cycles.
        do_aw(4'hA, 32'h100, 0, 3, 2'b11, 2'b10);
        do_beat(8'h99, 8'hFF, 1'b1);
        do_b(5);
        dbg_read(32'h100, 8'hD0);

        // Reset mid-burst abandons the transaction but keeps memory.
        do_aw(4'h6, 32'h700, 3, 3, 2'b01, 2'b00);
        void'(sb.pop_back());
        do_beat(8'hC1, 8'hFF, 1'b0);
        areset = 1'b1;
        tick();
        check("rst_data_wready", wready, 0);
        check("rst_data_awready", awready, 0);
        check("rst_data_bvalid", bvalid, 0);
        check("rst_data_bid", bid, 0);
        check("rst_data_bresp", bresp, 0);
        areset = 1'b0;
        tick();
        check("rst_data_awready_after", awready, 1);
        tick();
        check("rst_data_no_b", bvalid, 0);
        dbg_read(32'h700, 8'hC1);
        dbg_read(32'h118, 8'hA1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4_slave_write_responder.md
AXI4_SLAVE_WRITE_RESPONDER -- requirements
Module: axi4_slave_write_responder

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, meaning AWADDR width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, meaning WDATA width; STRB = DATA_WIDTH/8.
REQ-003 SHALL have parameter MEM_BYTES, default 4096, meaning internal byte-memory depth.
REQ-004 SHALL have parameter BASE_ADDR, default 0, meaning first decoded byte address.
REQ-005 SHALL have one clock and a synchronous active-high reset: aclk in 1, all logic on the rising edge; areset in 1, synchronous active-high reset.
REQ-006 SHALL have the write address channel ports:
- awid in 4, transaction ID.
- awaddr in ADDRESS_WIDTH, start address.
- awlen in 8, beats-1.
- awsize in 3, log2 of bytes per beat.
- awburst in 2, 00 FIXED / 01 INCR / 10 WRAP / 11 RESERVED.
- awvalid in 1.
- awready out 1.
REQ-007 SHALL have the write data channel ports:
- wdata in DATA_WIDTH.
- wstrb in STRB.
- wlast in 1.
- wvalid in 1.
- wready out 1.
REQ-008 SHALL have the write response channel ports:
- bid out 4.
- bresp out 2, 00 OKAY / 10 SLVERR / 11 DECERR.
- bvalid out 1.
- bready in 1.
REQ-009 SHALL have a debug read port:
- dbg_addr in ADDRESS_WIDTH, byte address.
- dbg_data out 8, memory byte; registered, 1-cycle latency; 0 if out of range.

Function
REQ-010 SHALL implement FSM IDLE -> DATA -> RESP -> IDLE; one transaction at a time, no outstanding writes.
REQ-011 Output drive per state:
- awready = 1 only in IDLE.
- wready = 1 only in DATA.
- bvalid = 1 only in RESP.
REQ-012 AW handshake (awvalid&awready) in cycle T SHALL capture awid/awaddr/awlen/awsize/awburst, clear beat counter and error flag, and enter DATA with wready=1 at T+1.
REQ-013 At AW acceptance the error flag SHALL be set:
- DECERR if awaddr is outside [BASE_ADDR, BASE_ADDR+MEM_BYTES).
- Otherwise SLVERR if awburst=RESERVED, 2^awsize > STRB, or WRAP with awlen not in {1,3,7,15}.
REQ-014 Each W handshake with no AW-time error SHALL write byte lane i (wstrb[i]=1) to address (beat_addr & ~(STRB-1)) + i - BASE_ADDR.
REQ-015 Beat address update:
- FIXED: unchanged.
- INCR: (addr aligned to 2^size) + 2^size.
- WRAP: as INCR, but on reaching lower + 2^size*(awlen+1) return to lower = floor(awaddr / total) * total.
REQ-016 An INCR beat whose address leaves the decoded range SHALL NOT be written and SHALL set DECERR; later beats are still accepted and also not written.
REQ-017 WLAST on a beat before beat awlen SHALL end the burst at that beat and set SLVERR if no error is set; earlier beats remain written.
REQ-018 Beat awlen without WLAST SHALL end the burst and set SLVERR if no error is set.
REQ-019 Error precedence: DECERR over SLVERR; once set, the error SHALL NOT be downgraded within the transaction.
REQ-020 The cycle after the final W handshake SHALL enter RESP with bvalid=1, bid=captured awid, bresp = error flag (00 if none).
REQ-021 In RESP, bvalid/bid/bresp SHALL stay stable until bready=1; the B handshake returns to IDLE and awready=1 the next cycle.
REQ-022 Exclusive access SHALL NOT be supported; EXOKAY SHALL never be returned.
REQ-023 A debug read and a W write to the same byte in the same cycle SHALL return the old value.

Reset
REQ-024 While areset=1 at a clock edge, the next-cycle outputs SHALL be: state IDLE, awready=0, wready=0, bvalid=0, bid=0, bresp=0, dbg_data=0.
REQ-025 The first edge with areset=0 SHALL set awready=1.
REQ-026 Reset during DATA or RESP SHALL abandon the transaction with no B response; memory contents SHALL NOT be cleared.

Verification
REQ-027 INCR, awaddr=0x100, awlen=3, awsize=3, wstrb=0xFF, data 0x11..,0x22..,0x33..,0x44.. -> bytes 0x100-0x11F hold the data; bid=awid; bresp=00; B one cycle after the last beat.
REQ-028 WRAP, awaddr=0x118, awlen=3, awsize=3 -> beats land at 0x118, 0x100, 0x108, 0x110; bresp=00.
REQ-029 FIXED, awaddr=0x203, awsize=0, awlen=1, wstrb=0x08, data bytes 0xAA then 0x55 -> byte 0x203=0x55; bresp=00.
REQ-030 awaddr=0x2000 (MEM_BYTES=4096), awlen=1 -> both beats accepted, no bytes changed, bresp=11.
REQ-031 awlen=3 with WLAST on beat 2 -> B after beat 2, bresp=10, beats 1-2 written.
REQ-032 bready held low 5 cycles -> bvalid, bid, bresp stable and awready=0 throughout; areset pulse during DATA -> next cycle wready=0, awready=0, bvalid=0.
